// File: rtl/d5m_emu_pkg.sv
// D5M sensor emulator: shared FSM states, pattern codes,
// LFSR seed/taps and Bayer levels.
package d5m_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FSTART,
    ST_LINE,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_BAYER = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  localparam logic [11:0] LFSR_SEED = 12'hACE;
  // taps 12,11,10,4 -> bits 11,10,9,3
  localparam logic [11:0] LFSR_TAPS = 12'hE08;

  localparam logic [11:0] BAYER_HI  = 12'hFFF;
  localparam logic [11:0] BAYER_MID = 12'h800;
  localparam logic [11:0] BAYER_LO  = 12'h000;

  function automatic logic [11:0] lfsr_step(
    input logic [11:0] v
  );
    return {v[10:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/d5m_emu_lfsr.sv
// D5M sensor emulator: 12-bit Fibonacci LFSR.
// value shows the seed while load is high.
module d5m_emu_lfsr
  import d5m_emu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  output logic [11:0] value
);

  logic [11:0] q;

  assign value = load ? LFSR_SEED : q;

  // hold, reseed, or advance past the value just emitted
  always_ff @(posedge clk) begin
    if (rst) q <= LFSR_SEED;
    else     q <= adv ? lfsr_step(value) : value;
  end

endmodule

// File: rtl/d5m_sensor_emu.sv
// D5M camera transmit-side emulator (FVAL/LVAL/12-bit data).
// Optional `D5M_EMU_TRIGGER_EN adds iTRIG one-shot frame trigger.
module d5m_sensor_emu
  import d5m_emu_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_ACTIVE  = 480,
  parameter int V_BLANK   = 20,
  parameter int FV_LV_DLY = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
`ifdef D5M_EMU_TRIGGER_EN
  input  logic        iTRIG,
`endif
  input  logic [1:0]  iPATTERN,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [11:0] oD,
  output logic [15:0] oFRAME_CNT,
  output logic        oFRAME_DONE
);

  localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int CW = $clog2(VB_LEN + FV_LV_DLY + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [YW-1:0] y, ny;
  logic [1:0]    pat_q, pat_sel;
  logic [11:0]   nd, lfsr_val;
  logic          go, last_line, fdone_n;

  assign pat_sel   = (state == ST_FSTART) ? iPATTERN : pat_q;
  assign last_line = (y == YW'(V_ACTIVE - 1));
  assign fdone_n   = (state == ST_LINE) && (nstate == ST_VBLANK);

`ifdef D5M_EMU_TRIGGER_EN
  logic pend, enter_fs;

  assign enter_fs = (nstate == ST_FSTART) && (state != ST_FSTART);
  assign go       = iEN && (pend || iTRIG);

  // pending trigger, consumed when a frame starts
  always_ff @(posedge iCLK) begin
    if (iRST)          pend <= 1'b0;
    else if (enter_fs) pend <= 1'b0;
    else if (iTRIG)    pend <= 1'b1;
  end
`else
  assign go = iEN;
`endif

  d5m_emu_lfsr u_lfsr (
    .clk   (iCLK),
    .rst   (iRST),
    .load  (state == ST_FSTART),
    .adv   (nstate == ST_LINE),
    .value (lfsr_val)
  );

  // timing FSM state, in-state cycle counter and row counter
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      y     <= '0;
      pat_q <= PAT_XRAMP;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      y     <= ny;
      if (state == ST_FSTART) pat_q <= iPATTERN;
    end
  end

  // next state, counters and next pixel value
  always_comb begin
    nstate = state;
    ncnt   = cnt + 1'b1;
    ny     = y;
    nd     = 12'h000;
    unique case (state)
      ST_IDLE: begin
        if (go) nstate = ST_FSTART;
      end
      ST_FSTART: begin
        ny = '0;
        if (cnt == CW'(FV_LV_DLY - 1)) nstate = ST_LINE;
      end
      ST_LINE: begin
        if (cnt == CW'(H_ACTIVE - 1)) begin
          nstate = last_line ? ST_VBLANK : ST_HBLANK;
          ny     = last_line ? '0 : y + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (cnt == CW'(H_BLANK - 1)) nstate = ST_LINE;
      end
      ST_VBLANK: begin
        if (cnt == CW'(VB_LEN - 1))
          nstate = go ? ST_FSTART : ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
    if (nstate != state) ncnt = '0;
    if (nstate == ST_LINE) begin
      unique case (pat_sel)
        PAT_XRAMP: nd = 12'(ncnt);
        PAT_YRAMP: nd = 12'(ny);
        PAT_BAYER: begin
          unique case ({ny[0], ncnt[0]})
            2'b00:   nd = BAYER_MID;
            2'b01:   nd = BAYER_HI;
            2'b10:   nd = BAYER_LO;
            default: nd = BAYER_MID;
          endcase
        end
        default:   nd = lfsr_val;
      endcase
    end
  end

  // registered outputs aligned to the state being entered
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oFVAL       <= 1'b0;
      oLVAL       <= 1'b0;
      oD          <= 12'h000;
      oFRAME_DONE <= 1'b0;
      oFRAME_CNT  <= 16'h0000;
    end else begin
      oFVAL       <= nstate inside {ST_FSTART, ST_LINE, ST_HBLANK};
      oLVAL       <= (nstate == ST_LINE);
      oD          <= nd;
      oFRAME_DONE <= fdone_n;
      oFRAME_CNT  <= oFRAME_CNT + {15'h0, fdone_n};
    end
  end

endmodule

// File: tb/tb_d5m_sensor_emu.sv
// Directed bench for d5m_sensor_emu with a small 8x4 frame.
// Covers patterns, iEN drop, mid-line reset and optional trigger.
module tb_d5m_sensor_emu;

  logic        iCLK = 1'b0;
  logic        iRST, iEN, iTRIG;
  logic [1:0]  iPATTERN;
  logic        oFVAL, oLVAL, oFRAME_DONE;
  logic [11:0] oD;
  logic [15:0] oFRAME_CNT;

  int vectors = 0;
  int miscompares = 0;

  always #5 iCLK = ~iCLK;

  d5m_sensor_emu #(
    .H_ACTIVE  (8),
    .H_BLANK   (4),
    .V_ACTIVE  (4),
    .V_BLANK   (2),
    .FV_LV_DLY (2)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iEN         (iEN),
`ifdef D5M_EMU_TRIGGER_EN
    .iTRIG       (iTRIG),
`endif
    .iPATTERN    (iPATTERN),
    .oFVAL       (oFVAL),
    .oLVAL       (oLVAL),
    .oD          (oD),
    .oFRAME_CNT  (oFRAME_CNT),
    .oFRAME_DONE (oFRAME_DONE)
  );

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] lstep(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[10] ^ v[9] ^ v[3]};
  endfunction

  function automatic logic [11:0] expd(input logic [1:0] pat,
                                       input int x, input int y,
                                       input logic [11:0] lf);
    case (pat)
      2'd0: return 12'(x);
      2'd1: return 12'(y);
      2'd2: begin
        if (y % 2 == 0) return (x % 2 == 1) ? 12'hFFF : 12'h800;
        else            return (x % 2 == 1) ? 12'h800 : 12'h000;
      end
      default: return lf;
    endcase
  endfunction

  // entered just after the first FSTART cycle has been observed
  task automatic frame(input logic [1:0]  pat,
                       input logic [15:0] n,
                       input int          mid_line,
                       input logic [1:0]  mid_pat,
                       input int          drop_line);
    logic [11:0] lf;
    lf = 12'hACE;
    tick;
    chk("fstart2", {oFVAL, oLVAL, oD}, {2'b10, 12'h000});
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        tick;
        chk("pixel", {oFVAL, oLVAL, oFRAME_DONE, oD},
            {3'b110, expd(pat, x, y, lf)});
        if (pat == 2'd3 && y == 0 && x == 0)
          chk("lfsr_seed", oD, 12'hACE);
        if (pat == 2'd3 && y == 0 && x == 1)
          chk("lfsr_2nd", oD, 12'h59D);
        lf = lstep(lf);
        if (y == mid_line && x == 3) iPATTERN = mid_pat;
        if (y == drop_line && x == 3) iEN = 1'b0;
      end
      if (y < 3) begin
        for (int h = 0; h < 4; h++) begin
          tick;
          chk("hblank", {oFVAL, oLVAL, oFRAME_DONE, oD},
              {3'b100, 12'h000});
        end
      end
    end
    tick;
    chk("fdone", {oFVAL, oLVAL, oFRAME_DONE, oD}, {3'b001, 12'h000});
    chk("fcnt", oFRAME_CNT, n);
    for (int v = 1; v < 24; v++) begin
      tick;
      chk("vblank", {oFVAL, oLVAL, oFRAME_DONE, oD}, 32'h0);
    end
  endtask

  initial begin
    iRST     = 1'b1;
    iEN      = 1'b1;
    iPATTERN = 2'd0;
`ifdef D5M_EMU_TRIGGER_EN
    iTRIG    = 1'b1;
`else
    iTRIG    = 1'b0;
`endif
    tick;
    tick;
    chk("rst_fval", oFVAL, 1'b0);
    chk("rst_lval", oLVAL, 1'b0);
    chk("rst_d", oD, 12'h000);
    chk("rst_done", oFRAME_DONE, 1'b0);
    chk("rst_cnt", oFRAME_CNT, 16'h0);

    iRST = 1'b0;
    tick;
    chk("fstart1", {oFVAL, oLVAL}, 2'b10);
    frame(2'd0, 16'd1, -1, 2'd0, -1);

    iPATTERN = 2'd1;
    tick;
    chk("fstart1", {oFVAL, oLVAL}, 2'b10);
    frame(2'd1, 16'd2, -1, 2'd0, -1);

    iPATTERN = 2'd2;
    tick;
    chk("fstart1", {oFVAL, oLVAL}, 2'b10);
    frame(2'd2, 16'd3, 1, 2'd3, -1);

    tick;
    chk("fstart1", {oFVAL, oLVAL}, 2'b10);
    frame(2'd3, 16'd4, -1, 2'd0, -1);

    iPATTERN = 2'd0;
    tick;
    chk("fstart1", {oFVAL, oLVAL}, 2'b10);
    frame(2'd0, 16'd5, -1, 2'd0, 2);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("idle_hold", {oFVAL, oLVAL, oFRAME_DONE, oD}, 32'h0);
    end
    chk("idle_cnt", oFRAME_CNT, 16'd5);

    iEN = 1'b1;
    tick;
    chk("restart", {oFVAL, oLVAL}, 2'b10);
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("pre_rst", {oLVAL, oD}, {1'b1, 12'(i)});
    end
    iRST  = 1'b1;
    iTRIG = 1'b0;
    tick;
    chk("midrst", {oFVAL, oLVAL, oFRAME_DONE, oD}, 32'h0);
    chk("midrst_cnt", oFRAME_CNT, 16'h0);
    iRST = 1'b0;
    iEN  = 1'b0;
    tick;
    chk("post_rst", {oFVAL, oLVAL}, 2'b00);

`ifdef D5M_EMU_TRIGGER_EN
    iEN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("no_trig", {oFVAL, oLVAL}, 2'b00);
    end
    iTRIG = 1'b1;
    tick;
    chk("trig_start", {oFVAL, oLVAL}, 2'b10);
    iTRIG = 1'b0;
    frame(2'd0, 16'd1, -1, 2'd0, -1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("one_shot", {oFVAL, oLVAL}, 2'b00);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
